// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, field positions, immediate kinds
// and the registered bundle the decode stage hands to execute.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int REG_ADDR_W    = 5;
  localparam int OPCODE_LSB    = 0;
  localparam int OPCODE_W      = 7;
  localparam int RD_LSB        = 7;
  localparam int FUNCT3_LSB    = 12;
  localparam int FUNCT3_W      = 3;
  localparam int RS1_LSB       = 15;
  localparam int RS2_LSB       = 20;
  localparam int FUNCT7_B5_BIT = 30;

  // IMM_NONE is a legal format with no immediate (R-type); IMM_BAD is unknown.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_BAD
  } immType_t;

  typedef struct packed {
    logic [31:0]           pc;
    logic [31:0]           rs1Val;
    logic [31:0]           rs2Val;
    logic [31:0]           imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [OPCODE_W-1:0]   opcode;
    logic [FUNCT3_W-1:0]   funct3;
    logic                  funct7B5;
    logic                  illegal;
  } decodedInstr_t;

  function automatic immType_t decodeImmType(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      OP_REG:                   return IMM_NONE;
      default:                  return IMM_BAD;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction and legality check for one RV32
// instruction word.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic        illegal
);

  immType_t immType;

  assign immType = decodeImmType(instr[OPCODE_LSB +: OPCODE_W]);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    imm     = '0;
    illegal = 1'b0;
    case (immType)
      IMM_I:    imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:    imm = {instr[31:12], 12'b0};
      IMM_J:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_NONE: imm = '0;
      default:  illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode pipeline stage: register-file read, immediate generation and a
// one-entry output register with valid/ready handshake. Define
// ID_WB_BYPASS_EN to forward writeback data instead of stalling on a hazard.
module instr_decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,

  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,

  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,

  input  logic        flush,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7_b5,
  output logic        out_illegal
);

  logic [REG_ADDR_W-1:0] rs1Addr;
  logic [REG_ADDR_W-1:0] rs2Addr;
  logic [31:0]           rs1Val;
  logic [31:0]           rs2Val;
  logic [31:0]           immNext;
  logic                  illegalNext;
  logic                  hazardStall;
  logic                  transfer;
  decodedInstr_t         nextOut;
  decodedInstr_t         outReg;

  assign rs1Addr     = in_instr[RS1_LSB +: REG_ADDR_W];
  assign rs2Addr     = in_instr[RS2_LSB +: REG_ADDR_W];
  assign rf_rs1_addr = rs1Addr;
  assign rf_rs2_addr = rs2Addr;

  imm_gen immGenInst (
    .instr   (in_instr),
    .imm     (immNext),
    .illegal (illegalNext)
  );

`ifdef ID_WB_BYPASS_EN
  assign hazardStall = 1'b0;

  // x0 always reads zero; otherwise a same-cycle writeback wins over the RF.
  always_comb begin
    rs1Val = (rs1Addr == '0) ? '0 : rf_rs1_data;
    rs2Val = (rs2Addr == '0) ? '0 : rf_rs2_data;
    if (wb_we && rs1Addr != '0 && wb_addr == rs1Addr) rs1Val = wb_data;
    if (wb_we && rs2Addr != '0 && wb_addr == rs2Addr) rs2Val = wb_data;
  end
`else
  logic unusedWbData;

  // The RF write lands this cycle, so hold one cycle and read it next time.
  assign hazardStall = in_valid && wb_we && (wb_addr != '0) &&
                       ((wb_addr == rs1Addr) || (wb_addr == rs2Addr));
  assign unusedWbData = ^wb_data;

  always_comb begin
    rs1Val = (rs1Addr == '0) ? '0 : rf_rs1_data;
    rs2Val = (rs2Addr == '0) ? '0 : rf_rs2_data;
  end
`endif

  assign in_ready = (!out_valid || out_ready) && !hazardStall && !flush;
  assign transfer = in_valid && in_ready;

  always_comb begin
    nextOut          = '0;
    nextOut.pc       = in_pc;
    nextOut.rs1Val   = rs1Val;
    nextOut.rs2Val   = rs2Val;
    nextOut.imm      = immNext;
    nextOut.rd       = in_instr[RD_LSB +: REG_ADDR_W];
    nextOut.opcode   = in_instr[OPCODE_LSB +: OPCODE_W];
    nextOut.funct3   = in_instr[FUNCT3_LSB +: FUNCT3_W];
    nextOut.funct7B5 = in_instr[FUNCT7_B5_BIT];
    nextOut.illegal  = illegalNext;
  end

  // Flush beats both capture and hold; the data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this is a handful of pipeline flops, not a memory array, so the
      // whole bundle is cleared on reset to give execute a defined view.
      out_valid <= 1'b0;
      outReg    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      out_valid <= 1'b1;
      outReg    <= nextOut;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc        = outReg.pc;
  assign out_rs1_val   = outReg.rs1Val;
  assign out_rs2_val   = outReg.rs2Val;
  assign out_imm       = outReg.imm;
  assign out_rd        = outReg.rd;
  assign out_opcode    = outReg.opcode;
  assign out_funct3    = outReg.funct3;
  assign out_funct7_b5 = outReg.funct7B5;
  assign out_illegal   = outReg.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed literal cases followed
// by randomized traffic compared every cycle against a behavioural model.
module tb_instr_decode_stage;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7_b5, out_illegal;

  int nTests = 0;
  int nFail  = 0;

  instr_decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7_b5(out_funct7_b5), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT; written only through the writeback port.
  logic [31:0] regs [32];
  assign rf_rs1_data = regs[rf_rs1_addr];
  assign rf_rs2_data = regs[rf_rs2_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        expValid;
  logic [31:0] expPc, expRs1, expRs2, expImm;
  logic [4:0]  expRd;
  logic [6:0]  expOp;
  logic [2:0]  expF3;
  logic        expF7, expIll;

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic logic [31:0] modelImm(input logic [31:0] i);
    int op = int'(i[6:0]);
    case (op)
      7'h03, 7'h13, 7'h67: return 32'(sext(int'(i[31:20]), 12));
      7'h23: return 32'(sext(int'(i[31:25]) * 32 + int'(i[11:7]), 12));
      7'h63: return 32'(sext(int'(i[31]) * 4096 + int'(i[7]) * 2048 +
                             int'(i[30:25]) * 32 + int'(i[11:8]) * 2, 13));
      7'h37, 7'h17: return i[31:12] * 32'd4096;
      7'h6F: return 32'(sext(int'(i[31]) * 1048576 + int'(i[19:12]) * 4096 +
                             int'(i[20]) * 2048 + int'(i[30:21]) * 2, 21));
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit modelIllegal(input logic [31:0] i);
    int op = int'(i[6:0]);
    bit known = (op == 7'h03) || (op == 7'h13) || (op == 7'h67) || (op == 7'h23) ||
                (op == 7'h63) || (op == 7'h37) || (op == 7'h17) || (op == 7'h6F) ||
                (op == 7'h33);
    return !known || (i[1:0] != 2'b11);
  endfunction

  function automatic bit modelStall();
    logic [4:0] r1 = in_instr[19:15];
    logic [4:0] r2 = in_instr[24:20];
    return !BYPASS && in_valid && wb_we && (wb_addr != 0) && (wb_addr == r1 || wb_addr == r2);
  endfunction

  function automatic bit modelReady();
    return (!expValid || out_ready) && !modelStall() && !flush;
  endfunction

  function automatic logic [31:0] modelOperand(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (BYPASS && wb_we && wb_addr == a) return wb_data;
    return regs[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expValid <= 1'b0;
      expPc <= 0; expRs1 <= 0; expRs2 <= 0; expImm <= 0;
      expRd <= 0; expOp <= 0; expF3 <= 0; expF7 <= 0; expIll <= 0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'hA5A5_0000 | 32'(i);
    end else begin
      if (flush) expValid <= 1'b0;
      else if (in_valid && modelReady()) begin
        expValid <= 1'b1;
        expPc    <= in_pc;
        expRs1   <= modelOperand(in_instr[19:15]);
        expRs2   <= modelOperand(in_instr[24:20]);
        expImm   <= modelImm(in_instr);
        expIll   <= modelIllegal(in_instr);
        expRd    <= in_instr[11:7];
        expOp    <= in_instr[6:0];
        expF3    <= in_instr[14:12];
        expF7    <= in_instr[30];
      end else if (out_ready) expValid <= 1'b0;
      if (wb_we && wb_addr != 0) regs[wb_addr] <= wb_data;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, modelReady());
    check("rf_rs1_addr", rf_rs1_addr, in_instr[19:15]);
    check("rf_rs2_addr", rf_rs2_addr, in_instr[24:20]);
    check("out_valid", out_valid, expValid);
    check("out_pc", out_pc, expPc);
    check("out_rs1_val", out_rs1_val, expRs1);
    check("out_rs2_val", out_rs2_val, expRs2);
    check("out_imm", out_imm, expImm);
    check("out_rd", out_rd, expRd);
    check("out_opcode", out_opcode, expOp);
    check("out_funct3", out_funct3, expF3);
    check("out_funct7_b5", out_funct7_b5, expF7);
    check("out_illegal", out_illegal, expIll);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] opTable [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [31:0] ins;
    rst = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFD08293; in_pc = 32'h40;
    out_ready = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) step();
    check("lit reset out_valid", out_valid, 0);
    check("lit reset out_imm", out_imm, 0);
    check("lit reset out_pc", out_pc, 0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Preload x1=7, x3=0x11 through writeback with no instruction in flight.
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd7; step();
    wb_addr = 5'd3; wb_data = 32'h11; step();
    wb_we = 1'b0;

    // ADDI x5,x1,-3
    in_valid = 1'b1; in_instr = 32'hFFD08293; in_pc = 32'h100; out_ready = 1'b1;
    step();
    check("lit addi out_valid", out_valid, 1);
    check("lit addi out_imm", out_imm, 32'hFFFFFFFD);
    check("lit addi out_rd", out_rd, 5);
    check("lit addi out_rs1_val", out_rs1_val, 7);

    // Backpressure for 3 cycles with ADD x7,x1,x3 waiting.
    out_ready = 1'b0; in_instr = 32'h003083B3; in_pc = 32'h104;
    repeat (3) begin
      step();
      check("lit hold out_rd", out_rd, 5);
      check("lit hold out_pc", out_pc, 32'h100);
      check("lit hold in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("lit add out_rd", out_rd, 7);
    check("lit add out_rs2_val", out_rs2_val, 32'h11);
    check("lit add out_imm", out_imm, 0);
    in_valid = 1'b0;
    step();
    check("lit drain out_valid", out_valid, 0);

    // Writeback to x3 while ADDI x8,x3,1 is presented.
    in_valid = 1'b1; in_instr = 32'h00118413; in_pc = 32'h108;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hCAFEF00D;
    #1;
`ifdef ID_WB_BYPASS_EN
    check("lit bypass in_ready", in_ready, 1);
    step();
    wb_we = 1'b0;
`else
    check("lit stall in_ready", in_ready, 0);
    step();
    check("lit stall out_valid", out_valid, 0);
    wb_we = 1'b0;
    #1;
    check("lit after stall in_ready", in_ready, 1);
    step();
`endif
    check("lit hazard out_valid", out_valid, 1);
    check("lit hazard out_rs1_val", out_rs1_val, 32'hCAFEF00D);

    // ADDI x9,x0,5 with writeback to x0.
    in_instr = 32'h00500493; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    #1;
    check("lit x0 in_ready", in_ready, 1);
    step();
    wb_we = 1'b0;
    check("lit x0 out_rs1_val", out_rs1_val, 0);
    check("lit x0 out_imm", out_imm, 5);

    in_instr = 32'hFE000CE3; step();
    check("lit beq out_imm", out_imm, 32'hFFFFFFF8);
    check("lit beq out_illegal", out_illegal, 0);
    in_instr = 32'h0000000B; step();
    check("lit op0b out_illegal", out_illegal, 1);
    in_instr = 32'h123450B7; step();
    check("lit lui out_imm", out_imm, 32'h12345000);
    in_instr = 32'h00000010; step();
    check("lit lowbits out_illegal", out_illegal, 1);

    // Flush while held, then reset while stalled.
    in_instr = 32'h00208113; step();
    out_ready = 1'b0; in_valid = 1'b0; step();
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300193;
    #1;
    check("lit flush in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    check("lit flush out_valid", out_valid, 0);
    check("lit flush out_rd", out_rd, 2);
    step();
    check("lit post flush out_rd", out_rd, 3);
    in_instr = 32'h00400213; step();
    check("lit stalled in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("lit rst out_valid", out_valid, 0);
    check("lit rst out_rd", out_rd, 0);
    check("lit rst out_imm", out_imm, 0);
    check("lit rst out_rs1_val", out_rs1_val, 0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("lit post rst in_ready", in_ready, 1);
    step();
    check("lit post rst out_valid", out_valid, 1);
    check("lit post rst out_rd", out_rd, 4);

    // Randomized traffic; the model and compare process do the checking.
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) < 9) ins[6:0] = opTable[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) < 8) ins[19:15] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) ins[24:20] = 5'($urandom_range(0, 7));
      in_instr  = ins;
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_we     = ($urandom_range(0, 9) < 3);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
